// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC datapath: ROM geometry and the
// coefficient-reader sequencer state encoding.
package ddc_pkg;

  localparam int ROM_AW = 11;  // 3 bank bits + 8 tap bits
  localparam int ROM_DW = 18;  // two's complement coefficient width
  localparam int BANK_W = 3;
  localparam int TAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fir_rd_state_t;

endpackage

// File: rtl/coef_skid_fifo.sv
// Small circular buffer that holds coefficients read from the ROM until
// the MAC takes them. Push and pop may happen in the same cycle. The
// entry count is exported so the reader can limit its outstanding reads.
module coef_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage array; contents need no reset because occ gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // The reader's credit rule must never let a write land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (occ != OCC_W'(DEPTH)));

endmodule

// File: rtl/fir_coef_reader.sv
// Read-side sequencer for the FIR coefficient ROM. A start walks one bank
// tap by tap, absorbs the ROM's one-cycle registered read latency and
// streams {coef, tap, last} to the MAC through a small buffer.
//
// Handshake: coef_valid means coef/coef_tap/coef_last hold a real entry;
// a transfer happens on every rising edge where coef_valid & coef_ready;
// while coef_valid & !coef_ready the three data outputs do not change, and
// coef_valid never drops without a transfer (except on reset).
module fir_coef_reader
  import ddc_pkg::*;
#(
  parameter int NTAPS  = 122,
  parameter int ADDR_W = ROM_AW,
  parameter int DATA_W = ROM_DW,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [BANK_W-1:0]   bank,
  output logic                busy,
  output logic                done,
  output logic                rom_ce,
  output logic                rom_oce,
  output logic                rom_reset,
  output logic [ADDR_W-1:0]   rom_ad,
  input  logic [DATA_W-1:0]   rom_dout,
  output logic [DATA_W-1:0]   coef,
  output logic [TAP_W-1:0]    coef_tap,
  output logic                coef_last,
  output logic                coef_valid,
  input  logic                coef_ready,
  output fir_rd_state_t       state_dbg
);

  localparam int FW    = DATA_W + TAP_W + 1;
  localparam int OCC_W = $clog2(DEPTH+1);

  fir_rd_state_t     state;
  fir_rd_state_t     state_nxt;
  logic [BANK_W-1:0] bank_q;
  logic [8:0]        tap;
  logic              inflight;
  logic [TAP_W-1:0]  inflight_tap;
  logic              rom_reset_q;
  logic [OCC_W-1:0]  occ;
  logic [FW-1:0]     head;
  logic              issue_ok;
  logic              last_issue;
  logic              drain_done;
  logic              pop;

  // Credit: outstanding reads (buffered + in flight) must stay below DEPTH.
  assign issue_ok   = (int'(occ) + int'(inflight)) < DEPTH;
  assign last_issue = (tap == 9'(NTAPS-1));
  assign drain_done = (occ == '0) && !inflight;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (issue_ok && last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ROM issue strobe, done pulse and busy window.
  always_comb begin
    rom_ce = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    case (state)
      FETCH: begin
        rom_ce = issue_ok;
        busy   = 1'b1;
      end
      DRAIN: begin
        done = drain_done;
        busy = !drain_done;
      end
      default: ;
    endcase
  end

  // Bank latch, tap counter and the one-cycle read-in-flight tracker.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_q       <= '0;
      tap          <= '0;
      inflight     <= 1'b0;
      inflight_tap <= '0;
    end else begin
      inflight <= rom_ce;
      if (state == IDLE && start) begin
        bank_q <= bank;
        tap    <= '0;
      end else if (rom_ce) begin
        inflight_tap <= tap[TAP_W-1:0];
        tap          <= tap + 1'b1;
      end
    end
  end

  // ROM synchronous reset follows reset_n one cycle late.
  always_ff @(posedge clk) begin
    rom_reset_q <= ~reset_n;
  end

  assign rom_reset = rom_reset_q;
  assign rom_oce   = 1'b1;
  assign rom_ad    = rom_ce ? ADDR_W'({bank_q, tap[TAP_W-1:0]}) : '0;

  assign coef_valid = (occ != '0);
  assign pop        = coef_valid && coef_ready;

  coef_skid_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data ({rom_dout, inflight_tap, (inflight_tap == TAP_W'(NTAPS-1))}),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign coef      = coef_valid ? head[FW-1 -: DATA_W] : '0;
  assign coef_tap  = coef_valid ? head[TAP_W:1] : '0;
  assign coef_last = coef_valid && head[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_fir_coef_reader.sv
// Bench for fir_coef_reader: ROM model, randomized ready, queue-based
// reference of each burst's addresses and coefficients.
module tb_fir_coef_reader;
  import ddc_pkg::*;

  localparam int NTAPS = 122;
  localparam int DEPTH = 4;
  localparam int WW    = 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [2:0]    bank = 3'd0;
  logic          busy, done, rom_ce, rom_oce, rom_reset;
  logic [10:0]   rom_ad;
  logic [17:0]   rom_dout;
  logic [17:0]   coef;
  logic [7:0]    coef_tap;
  logic          coef_last, coef_valid;
  logic          coef_ready = 1'b1;
  fir_rd_state_t state_dbg;

  fir_coef_reader #(.NTAPS(NTAPS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bank       (bank),
    .busy       (busy),
    .done       (done),
    .rom_ce     (rom_ce),
    .rom_oce    (rom_oce),
    .rom_reset  (rom_reset),
    .rom_ad     (rom_ad),
    .rom_dout   (rom_dout),
    .coef       (coef),
    .coef_tap   (coef_tap),
    .coef_last  (coef_last),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .state_dbg  (state_dbg)
  );

  // ROM model: one-cycle registered read, data = addr ^ 18'h15A5A
  logic [17:0] rom_q = '0;
  always @(posedge clk) if (rom_ce) rom_q <= {7'd0, rom_ad} ^ 18'h15A5A;
  assign rom_dout = rom_q;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [WW-1:0] exp_q[$];
  logic [10:0]   addr_q[$];
  bit            mon_en = 0;
  bit            model_busy = 0;
  bit            rst_last = 0;
  bit            first_seen = 0;
  bit            prev_stall = 0;
  logic [WW-1:0] prev_word;
  int            acc_cyc = 0;
  int            issued = 0;
  int            popped = 0;
  int            done_cnt = 0;
  int            done_lat = 0;
  int            ready_mode = 1;  // 0 stall, 1 always ready, 2 random

  always @(negedge clk) begin
    if (mon_en) begin
      bit pre_busy;
      bit exp_done;
      logic [WW-1:0] word;
      pre_busy = model_busy;
      exp_done = model_busy && (exp_q.size() == 0);
      word     = {coef, coef_tap, coef_last};

      check_eq("done", done, exp_done);
      check_eq("busy", busy, model_busy && !exp_done);
      check_eq("rom_oce", rom_oce, 1);
      check_eq("rom_reset", rom_reset, !rst_last);

      if (rom_ce) begin
        if (addr_q.size() == 0) check_eq("rom_ce_extra", 1, 0);
        else begin
          check_eq("rom_ad", rom_ad, addr_q.pop_front());
          check_eq("credit", (issued - popped) < DEPTH, 1);
          issued++;
        end
      end

      if (coef_valid && model_busy && !first_seen) begin
        first_seen = 1;
        check_eq("first_valid_lat", cyc - acc_cyc, 3);
      end

      if (prev_stall) begin
        check_eq("stall_valid", coef_valid, 1);
        check_eq("stall_hold", word, prev_word);
      end

      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) check_eq("coef_extra", 1, 0);
        else check_eq("coef_word", word, exp_q.pop_front());
        popped++;
      end
      prev_stall = coef_valid && !coef_ready;
      prev_word  = word;

      if (exp_done) begin
        model_busy = 0;
        done_cnt++;
        done_lat = cyc - acc_cyc;
      end

      if (reset_n && start && !pre_busy) begin
        model_busy = 1;
        acc_cyc    = cyc;
        issued     = 0;
        popped     = 0;
        first_seen = 0;
        for (int t = 0; t < NTAPS; t++) begin
          logic [10:0] a;
          a = {bank, 8'(t)};
          addr_q.push_back(a);
          exp_q.push_back({({7'd0, a} ^ 18'h15A5A), 8'(t), (t == NTAPS-1)});
        end
      end

      if (!reset_n) begin
        exp_q.delete();
        addr_q.delete();
        model_busy = 0;
        prev_stall = 0;
      end
      rst_last = reset_n;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       coef_ready = 1'b0;
        1:       coef_ready = 1'b1;
        default: coef_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic pulse_start(input logic [2:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    bank  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int dc;
    int n;
    dc = done_cnt;
    n  = 0;
    while (done_cnt == dc && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("done_seen", done_cnt != dc, 1);
  endtask

  task automatic wait_popped(input int k, input int limit);
    int n;
    n = 0;
    while (popped < k && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("popped_reached", popped >= k, 1);
  endtask

  task automatic wait_issued(input int k, input int limit);
    int n;
    n = 0;
    while (issued < k && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("issued_reached", issued >= k, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    reset_n    = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", coef_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rom_ce", rom_ce, 0);
    check_eq("rst_rom_ad", rom_ad, 0);
    check_eq("rst_coef", coef, 0);
    check_eq("rst_coef_tap", coef_tap, 0);
    check_eq("rst_coef_last", coef_last, 0);
    check_eq("rst_rom_reset", rom_reset, 1);
    check_eq("rst_rom_oce", rom_oce, 1);
    check_eq("rst_state", state_dbg, IDLE);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1;

    // 1: bank 0, always ready
    pulse_start(3'd0);
    wait_done(400);
    check_eq("t1_done_lat", done_lat, NTAPS + 3);

    // 2: bank 5, bank input changes two cycles after start
    @(posedge clk); #1;
    start = 1'b1;
    bank  = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bank  = 3'd2;
    wait_done(400);
    check_eq("t2_done_lat", done_lat, NTAPS + 3);

    // 3: stall for 20 cycles with tap 10 at the head
    pulse_start(3'd6);
    wait_popped(10, 200);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("t3_ce_stopped", rom_ce, 0);
    check_eq("t3_head_tap", coef_tap, 10);
    repeat (10) @(posedge clk);
    ready_mode = 1;
    wait_done(400);

    // 4: random ready, random banks
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      dc = done_cnt;
      pulse_start(3'($urandom_range(0, 7)));
      wait_done(2000);
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check_eq("t4_one_done", done_cnt, dc + 1);
      check_eq("t4_idle_busy", busy, 0);
    end

    // 5: starts in FETCH, DRAIN and done cycle ignored; restart right after done
    ready_mode = 1;
    pulse_start(3'd1);
    repeat (10) @(posedge clk);
    pulse_start(3'd7);
    wait_issued(NTAPS, 400);
    pulse_start(3'd4);
    wait_popped(NTAPS, 400);
    @(posedge clk); #1;
    start = 1'b1;
    bank  = 3'd2;
    @(posedge clk); #1;
    bank  = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_eq("t5_restart_lat", done_lat, NTAPS + 3);

    // 6: reset pulse mid-burst at tap 40
    pulse_start(3'd3);
    wait_popped(40, 400);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t6_valid", coef_valid, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_rom_ce", rom_ce, 0);
    check_eq("t6_rom_reset", rom_reset, 1);
    #1;
    dc = done_cnt;
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    check_eq("t6_no_done", done_cnt, dc);
    ready_mode = 2;
    pulse_start(3'd1);
    wait_done(2000);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
